// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one unified single-port memory between the pipeline's instruction
// fetch port (IF) and data port (MEM stage). Requests are serialised with a
// fair alternating grant. Address, write data and read data are registered,
// and each completed access returns a one-cycle ready pulse that the hazard
// logic uses to release its stall.
//
// Parameters
//   XLEN     address / data width
//   TIMEOUT  maximum cycles a granted access waits for mem_ack (watchdog only)
//
// Optional feature
//   ARB_TIMEOUT_EN  when defined, a wait counter abandons an access after
//                   TIMEOUT cycles without mem_ack. The matching ready pulses
//                   together with err and the matching rdata is loaded with 0.
//                   When undefined, the arbiter waits indefinitely and err is 0.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   reset      in   asynchronous active-low reset
//   if_req     in   fetch request, held until if_ready
//   if_addr    in   fetch address (PC)
//   if_rdata   out  registered fetched instruction
//   if_ready   out  one-cycle pulse, fetch complete
//   d_req      in   data request, held until d_ready
//   d_we       in   1 = store, 0 = load
//   d_addr     in   data address
//   d_wdata    in   store data
//   d_rdata    out  registered load data
//   d_ready    out  one-cycle pulse, data access complete
//   mem_req    out  memory access active
//   mem_we     out  memory write enable
//   mem_addr   out  memory address
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data, valid with mem_ack
//   mem_ack    in   memory completes the current access this cycle
//   err        out  one-cycle pulse alongside a ready pulse on a timeout
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            err
);

  // A zero timeout would abandon every access before the memory could answer.
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("mem_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_INSTR = 2'd2
  } state_t;

  // Encoding of the port that received the most recent grant.
  localparam logic LG_DATA  = 1'b0;
  localparam logic LG_INSTR = 1'b1;

  state_t state;
  state_t state_nxt;
  logic   last_grant;

  logic   if_elig;
  logic   d_elig;
  logic   grant_d;
  logic   grant_i;
  logic   busy;
  logic   done;
  logic   timed_out;

  // ---------------------------------------------------------------------------
  // State register (process 1 of 3)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every register samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      last_grant <= LG_INSTR;
    end else begin
      state <= state_nxt;
      if (grant_d)      last_grant <= LG_DATA;
      else if (grant_i) last_grant <= LG_INSTR;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic (process 2 of 3)
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block purely
  // combinational; a path that leaves state_nxt unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (grant_d)      state_nxt = S_DATA;
        else if (grant_i) state_nxt = S_INSTR;
      end
      S_DATA, S_INSTR: begin
        if (done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / grant decode (process 3 of 3)
  // ---------------------------------------------------------------------------
  // A port whose ready is pulsing this cycle has just been served; excluding it
  // here is what stops the same port being re-granted in its ready cycle.
  always_comb begin
    if_elig = if_req & ~if_ready;
    d_elig  = d_req  & ~d_ready;
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == S_IDLE) begin
      // Both eligible: serve the port that did not get the previous grant.
      grant_d = d_elig  & (~if_elig | (last_grant == LG_INSTR));
      grant_i = if_elig & (~d_elig  | (last_grant == LG_DATA));
    end
    busy    = (state != S_IDLE);
    mem_req = busy;
    // mem_ack beats the watchdog: timed_out is only raised without an ack.
    done    = busy & (mem_ack | timed_out);
  end

  // ---------------------------------------------------------------------------
  // Optional wait watchdog
  // ---------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  // The cycle in which the counter already shows TIMEOUT-1 is the TIMEOUT-th
  // cycle without an ack, so the access is dropped at the end of that cycle.
  assign timed_out = busy & ~mem_ack & (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (grant_d | grant_i) begin
      wait_cnt <= '0;
    end else if (busy & ~mem_ack & ~timed_out) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Registered datapath and ready pulses
  // ---------------------------------------------------------------------------
  // The mem_* registers load only at grant, so requester changes to address or
  // data while an access is in flight never reach the memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err       <= 1'b0;
`endif
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err      <= done & timed_out;
`endif

      if (grant_d) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end

      // Store completions load d_rdata too; the consumer ignores it.
      if (done && state == S_DATA) begin
        d_rdata <= timed_out ? '0 : mem_rdata;
        d_ready <= 1'b1;
      end
      if (done && state == S_INSTR) begin
        if_rdata <= timed_out ? '0 : mem_rdata;
        if_ready <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter that shares one unified single-port memory between the pipelined RISC-V CPU's instruction-fetch port (IF) and data port (MEM stage). It sits between the pipeline stages and the memory. It serialises requests with a fair alternating grant, registers the address, write data and read data, and returns a one-cycle ready pulse that the hazard logic uses to release stalls. The main decoder's MemWrite drives d_we.

## Interface
Parameters:
- XLEN, 32, address and data width.
- TIMEOUT, 15, maximum cycles a granted access waits for mem_ack (used only with the timeout watchdog).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  instruction fetch request; held until if_ready.
- if_addr  input  XLEN  fetch address (PC).
- if_rdata  output  XLEN  registered fetched instruction.
- if_ready  output  1  one-cycle pulse: if_rdata valid, fetch complete.
- d_req  input  1  data access request; held until d_ready.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  XLEN  data address (ALU result).
- d_wdata  input  XLEN  store data.
- d_rdata  output  XLEN  registered load data.
- d_ready  output  1  one-cycle pulse: access complete.
- mem_req  output  1  memory access active.
- mem_we  output  1  memory write enable.
- mem_addr  output  XLEN  memory address.
- mem_wdata  output  XLEN  memory write data.
- mem_rdata  input  XLEN  memory read data; valid when mem_ack = 1.
- mem_ack  input  1  memory completes the current access this cycle.
- err  output  1  one-cycle pulse with a ready pulse when the access timed out.

## Operation
- FSM states:
  - IDLE: no access in flight.
  - DATA: data access in flight.
  - INSTR: fetch in flight.
- mem_req = (state != IDLE). mem_we, mem_addr and mem_wdata are registers loaded at grant and held constant through the access.
- Grant rule in IDLE, with last_grant a 1-bit register, reset = INSTR:
  - Eligible port: its req = 1 and its ready = 0 in the current cycle. A port is never re-granted in the cycle its ready pulses.
  - Both eligible: grant IF if last_grant = DATA, otherwise grant DATA.
  - One eligible: grant that port.
  - Grant: load mem_* registers, set last_grant, go to DATA or INSTR.
- IF grant loads mem_we = 0 and mem_wdata = 0. Data grant loads mem_we = d_we and mem_wdata = d_wdata.
- DATA or INSTR with mem_ack = 1:
  - Capture mem_rdata into d_rdata or if_rdata.
  - Pulse the matching ready for the next cycle.
  - Return to IDLE.
- Store completion: d_rdata is still loaded from mem_rdata; its value is don't-care to the consumer.
- if_rdata and d_rdata hold their last value until overwritten.
- Requester changes of addr or data while granted are ignored; the latched values are used.
- mem_ack while IDLE is ignored.

## Timing
- Reset (asynchronous assert, any state): state = IDLE, last_grant = INSTR, all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_ready, d_ready, err). An in-flight access is abandoned with no ready pulse.
- Minimum latency:
  - Cycle 0: req seen in IDLE.
  - Cycle 1: mem_req = 1; mem_ack = 1 possible.
  - Cycle 2: ready = 1, rdata valid, state IDLE.
- Back-to-back:
  - A new request from the other port can be granted in cycle 2, so mem_req is high again in cycle 3.
  - The same port can be granted in cycle 3 at the earliest.
- Each ready pulse lasts exactly one cycle. if_ready and d_ready are never high in the same cycle.
- Memory waits: each cycle of mem_ack = 0 in DATA or INSTR adds one cycle of latency.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A wait counter clears on grant and increments each cycle in DATA or INSTR without mem_ack.
  - When it reaches TIMEOUT (mem_ack still 0), the arbiter goes to IDLE. The matching ready and err pulse together next cycle, and the matching rdata is loaded with 0.
  - mem_ack in the same cycle as the limit wins: normal completion, no err.
- ARB_TIMEOUT_EN undefined: no counter; the arbiter waits indefinitely; err tied to 0.

## Test plan
- Reset: drive reset = 0 mid-access (state DATA) -> mem_req falls immediately, all outputs 0. After release, if_req = 1 is granted first at cycle 0.
- Single fetch: if_req = 1, if_addr = 0x0000_0004, mem_ack in the first mem_req cycle with mem_rdata = 0x0050_0113 -> if_ready pulse in cycle 2, if_rdata = 0x0050_0113, mem_we = 0.
- Conflict: if_req and d_req both high from reset, zero-wait memory -> grant order DATA, IF, DATA, IF. d_ready and if_ready alternate every 2 cycles, never in the same cycle.
- Store with waits: d_req = 1, d_we = 1, d_addr = 0x100, d_wdata = 0xDEAD_BEEF, mem_ack after 3 wait cycles -> mem_we = 1 and mem_addr and mem_wdata stable for 4 cycles, then a single d_ready pulse.
- No re-grant: requester holds d_req high in its d_ready cycle -> no new grant that cycle. A second access starts only if d_req is still high the following cycle.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT = 15): fetch with mem_ack held at 0 -> after 15 waiting cycles, if_ready = err = 1 for one cycle, if_rdata = 0, mem_req = 0. Without the macro, mem_req stays high indefinitely.
